// File: rtl/ars_ladder_ctrl_if.sv
// Scalar-sequencer bundle: host start/scalar, ladder-step handshake and status.
// The controller uses the slave side; the host/point-op environment uses master.
interface ars_ladder_ctrl_if #(
    parameter int WIDTH = 233,
    parameter int CNT_W = 8
) ();
    logic             start;
    logic [WIDTH-1:0] k;
    logic             sel;
    logic             op_start;
    logic             op_done;
    logic [CNT_W-1:0] bit_idx;
    logic             busy;
    logic             done;
    logic             zero;

    modport master (
        output start, k, op_done,
        input  sel, op_start, bit_idx, busy, done, zero
    );

    modport slave (
        input  start, k, op_done,
        output sel, op_start, bit_idx, busy, done, zero
    );
endinterface

// File: rtl/ars_ladder_ctrl.sv
// Montgomery-ladder scalar sequencer: skips leading zeros of K, spends the leading
// one on ladder init, then issues one handshaked ladder step per remaining bit.
module ars_ladder_ctrl #(
    parameter int WIDTH = 233,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    ars_ladder_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SCAN  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] IDX_TOP = CNT_W'(WIDTH - 1);

    state_t             state_r, state_s;
    logic [WIDTH-1:0]   kreg_r, kreg_s;
    logic [CNT_W-1:0]   idx_r, idx_s;
    logic               accept_s;
    logic               zero_set_s;
    logic               idx_zero_s;
    logic               sel_r;
    logic               op_start_r;
    logic [CNT_W-1:0]   bit_idx_r;
    logic               busy_r;
    logic               done_r;
    logic               zero_r;

    assign idx_zero_s = (idx_r == {CNT_W{1'b0}});

    // Next-state, next scalar shift and next bit index.
    always_comb begin
        state_s    = state_r;
        kreg_s     = kreg_r;
        idx_s      = idx_r;
        accept_s   = 1'b0;
        zero_set_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    kreg_s   = bus.k;
                    idx_s    = IDX_TOP;
                    accept_s = 1'b1;
                    state_s  = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (idx_zero_s) begin
                    // Reaching bit 0 here means K was 0 or 1: no ladder steps.
                    zero_set_s = ~kreg_r[WIDTH-1];
                    state_s    = ST_FIN;
                end else begin
                    kreg_s  = {kreg_r[WIDTH-2:0], 1'b0};
                    idx_s   = idx_r - CNT_W'(1);
                    state_s = kreg_r[WIDTH-1] ? ST_ISSUE : ST_SCAN;
                end
            end
            ST_ISSUE: begin
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (!bus.op_done) begin
                    state_s = ST_WAIT;
                end else if (idx_zero_s) begin
                    state_s = ST_FIN;
                end else begin
                    kreg_s  = {kreg_r[WIDTH-2:0], 1'b0};
                    idx_s   = idx_r - CNT_W'(1);
                    state_s = ST_ISSUE;
                end
            end
            ST_FIN: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State, scalar and output registers; outputs load from next-state so SEL,
    // BIT_IDX and OP_START are all valid in the ISSUE cycle itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            kreg_r     <= {WIDTH{1'b0}};
            idx_r      <= {CNT_W{1'b0}};
            sel_r      <= 1'b0;
            op_start_r <= 1'b0;
            bit_idx_r  <= {CNT_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            zero_r     <= 1'b0;
        end else begin
            state_r    <= state_s;
            kreg_r     <= kreg_s;
            idx_r      <= idx_s;
            op_start_r <= (state_s == ST_ISSUE);
            busy_r     <= (state_s != ST_IDLE);
            done_r     <= (state_s == ST_FIN);
            if (state_s == ST_ISSUE) begin
                sel_r     <= kreg_s[WIDTH-1];
                bit_idx_r <= idx_s;
            end else begin
                sel_r     <= sel_r;
                bit_idx_r <= bit_idx_r;
            end
            if (accept_s) begin
                zero_r <= 1'b0;
            end else if (zero_set_s) begin
                zero_r <= 1'b1;
            end else begin
                zero_r <= zero_r;
            end
        end
    end

    assign bus.sel      = sel_r;
    assign bus.op_start = op_start_r;
    assign bus.bit_idx  = bit_idx_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.zero     = zero_r;

endmodule
